// File: rtl/mod_74xx_pkg.sv
// Shared definitions for the 74xx counter models: direction and active-low
// level constants, the next-state operation encoding and the load clamp.
package mod_74xx_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic ASSERT_N   = 1'b0;
    localparam logic DEASSERT_N = 1'b1;

    // Edge operation selected by the synchronous controls (clear is async)
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } op_t;

    // Limit a load value to the count range 0..modulus-1
    function automatic logic [MAX_WIDTH-1:0] clamp_mod(
        input logic [MAX_WIDTH-1:0] value,
        input logic [MAX_WIDTH:0]   modulus
    );
        if (33'(value) >= modulus) begin
            return 32'(modulus - 33'd1);
        end
        return value;
    endfunction

endpackage : mod_74xx_pkg

// File: rtl/mod_74xx_tc_detect.sv
// Terminal-count decode for modulus counters: high at the last state in the
// current count direction.
module mod_74xx_tc_detect
    import mod_74xx_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] Q,
    input  logic             UP,
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Top of range when counting up, zero when counting down
    always_comb begin
        TC = ((UP == DIR_UP) && (Q == MAX_Q)) ||
             ((UP == DIR_DOWN) && (Q == '0));
    end

endmodule : mod_74xx_tc_detect

// File: rtl/mod_74x169_n.sv
// 74x169-style presettable up/down modulus counter with async clear and
// cascadable ripple-carry output.
// Build option: MOD_74X169_N_RCO_REG_EN registers terminal count so RCO_N
// does not glitch on Q transitions (it then lags UP changes made between
// edges by one clock).
module mod_74x169_n
    import mod_74xx_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 64'd1 << WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             LOAD_N,
    input  logic             ENP_N,
    input  logic             ENT_N,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO_N
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Reject out-of-range configurations at elaboration
    if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("mod_74x169_n: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_mod
        $error("mod_74x169_n: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    op_t              op;
    logic [WIDTH-1:0] d_clamped;
    logic [WIDTH-1:0] q_next;
    logic             tc;
    logic             count_en;

    assign count_en  = (ENP_N == ASSERT_N) && (ENT_N == ASSERT_N);
    assign d_clamped = WIDTH'(clamp_mod(32'(D), 33'(MODULUS)));

    // Select the edge operation: load beats count beats hold
    always_comb begin
        op = OP_HOLD;
        if (LOAD_N == ASSERT_N) begin
            op = OP_LOAD;
        end else if (count_en) begin
            op = OP_COUNT;
        end
    end

    // Next count value; wrap comes from the modulus compare only
    always_comb begin
        q_next = Q;
        case (op)
            OP_LOAD: q_next = d_clamped;
            OP_COUNT: begin
                if (UP == DIR_UP) begin
                    q_next = (Q == MAX_Q) ? '0 : Q + WIDTH'(1);
                end else begin
                    q_next = (Q == '0) ? MAX_Q : Q - WIDTH'(1);
                end
            end
            default: q_next = Q;
        endcase
    end

    // Count register, cleared asynchronously
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

`ifdef MOD_74X169_N_RCO_REG_EN
    logic tc_next;
    logic tc_reg;

    mod_74xx_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .Q  (q_next),
        .UP (UP),
        .TC (tc_next)
    );

    // Terminal count captured from the value Q is about to take
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= tc_next;
        end
    end

    assign tc = tc_reg;
`else
    mod_74xx_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .Q  (Q),
        .UP (UP),
        .TC (tc)
    );
`endif

    // Carry out is gated only by the cascade enable
    assign RCO_N = ~(tc & (ENT_N == ASSERT_N));

endmodule : mod_74x169_n

// File: tb/tb_mod_74x169_n.sv
// Bench for mod_74x169_n (WIDTH=4, MODULUS=10); a second instance is
// cascaded on the first one's RCO_N. Works with or without
// MOD_74X169_N_RCO_REG_EN.
module tb_mod_74x169_n;

    logic       CLK;
    logic       CLR_N;
    logic       LOAD_N;
    logic       ENP_N;
    logic       ENT_N;
    logic       UP;
    logic [3:0] D;
    logic [3:0] q_lo;
    logic [3:0] q_hi;
    logic       rco_lo;
    logic       rco_hi;

    int checks   = 0;
    int failures = 0;

    mod_74x169_n #(.WIDTH(4), .MODULUS(10)) u_lo (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .LOAD_N (LOAD_N),
        .ENP_N  (ENP_N),
        .ENT_N  (ENT_N),
        .UP     (UP),
        .D      (D),
        .Q      (q_lo),
        .RCO_N  (rco_lo)
    );

    mod_74x169_n #(.WIDTH(4), .MODULUS(10)) u_hi (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .LOAD_N (LOAD_N),
        .ENP_N  (ENP_N),
        .ENT_N  (rco_lo),
        .UP     (UP),
        .D      (4'd0),
        .Q      (q_hi),
        .RCO_N  (rco_hi)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] val);
        LOAD_N = 1'b0;
        D      = val;
        step();
        LOAD_N = 1'b1;
    endtask

    initial begin
        CLR_N  = 1'b0;
        LOAD_N = 1'b1;
        ENP_N  = 1'b1;
        ENT_N  = 1'b0;
        UP     = 1'b0;
        D      = 4'd0;
        repeat (3) step();

        check("reset_q", 32'(q_lo), 32'd0);
`ifdef MOD_74X169_N_RCO_REG_EN
        check("reset_rco", 32'(rco_lo), 32'd1);
`else
        check("reset_rco", 32'(rco_lo), 32'd0);
`endif
        CLR_N = 1'b1;
        ENT_N = 1'b1;
        UP    = 1'b1;

        // Async clear mid-cycle, then held through loads
        load(4'd7);
        check("load7", 32'(q_lo), 32'd7);
        #2;
        CLR_N = 1'b0;
        #1;
        check("clr_async", 32'(q_lo), 32'd0);
        LOAD_N = 1'b0;
        D      = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("clr_hold", 32'(q_lo), 32'd0);
        end
        CLR_N  = 1'b1;
        LOAD_N = 1'b1;

        // Up wrap
        UP    = 1'b1;
        ENP_N = 1'b0;
        ENT_N = 1'b0;
        load(4'd8);
        check("up_q8", 32'(q_lo), 32'd8);
        check("up_rco8", 32'(rco_lo), 32'd1);
        step();
        check("up_q9", 32'(q_lo), 32'd9);
        check("up_rco9", 32'(rco_lo), 32'd0);
        step();
        check("up_q0", 32'(q_lo), 32'd0);
        check("up_rco0", 32'(rco_lo), 32'd1);
        step();
        check("up_q1", 32'(q_lo), 32'd1);
        check("up_rco1", 32'(rco_lo), 32'd1);

        // Down wrap
        UP = 1'b0;
        load(4'd1);
        check("dn_q1", 32'(q_lo), 32'd1);
        check("dn_rco1", 32'(rco_lo), 32'd1);
        step();
        check("dn_q0", 32'(q_lo), 32'd0);
        check("dn_rco0", 32'(rco_lo), 32'd0);
        step();
        check("dn_q9", 32'(q_lo), 32'd9);
        check("dn_rco9", 32'(rco_lo), 32'd1);
        step();
        check("dn_q8", 32'(q_lo), 32'd8);
        check("dn_rco8", 32'(rco_lo), 32'd1);

        // ENP_N high holds
        ENP_N = 1'b1;
        load(4'd5);
        for (int i = 0; i < 4; i++) begin
            step();
            check("enp_hold", 32'(q_lo), 32'd5);
        end
        check("enp_rco", 32'(rco_lo), 32'd1);

        // ENT_N high holds and masks RCO_N at terminal count
        UP    = 1'b1;
        ENP_N = 1'b0;
        ENT_N = 1'b1;
        load(4'd9);
        check("ent_q9", 32'(q_lo), 32'd9);
        check("ent_rco_masked", 32'(rco_lo), 32'd1);
        step();
        check("ent_hold", 32'(q_lo), 32'd9);
        check("ent_rco_masked2", 32'(rco_lo), 32'd1);
        ENT_N = 1'b0;
        #1;
        check("ent_rco_unmasked", 32'(rco_lo), 32'd0);

        // Load priority over count, clamp
        load(4'd13);
        check("clamp13", 32'(q_lo), 32'd9);
        load(4'd10);
        check("clamp10", 32'(q_lo), 32'd9);
        ENT_N = 1'b1;
        load(4'd3);
        check("load3_ent", 32'(q_lo), 32'd3);

        // Clear while counting discards the edge operation
        ENT_N = 1'b0;
        step();
        check("cnt4", 32'(q_lo), 32'd4);
        #2;
        CLR_N = 1'b0;
        #1;
        check("clr_midcount", 32'(q_lo), 32'd0);
        step();
        check("clr_midcount_edge", 32'(q_lo), 32'd0);
        CLR_N = 1'b1;

        // Two-digit decade cascade
        UP    = 1'b1;
        ENP_N = 1'b0;
        ENT_N = 1'b0;
        check("casc_start", 32'({q_hi, q_lo}), 32'h00);
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 10) check("casc_10", 32'({q_hi, q_lo}), 32'h10);
            if (n == 55) check("casc_55", 32'({q_hi, q_lo}), 32'h55);
            if (n == 99) begin
                check("casc_99", 32'({q_hi, q_lo}), 32'h99);
                check("casc_99_rco_hi", 32'(rco_hi), 32'd0);
            end
            if (n == 100) check("casc_100", 32'({q_hi, q_lo}), 32'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_74x169_n
